// File: rtl/bus_pkg.sv
// Shared constants and types for the CPU-side bus responder.
package bus_pkg;

   localparam logic [15:0] IF_ADDR  = 16'hFF0F;
   localparam logic [15:0] IE_ADDR  = 16'hFFFF;
   localparam logic [15:0] HRAM_END = 16'hFFFE;
   localparam int unsigned IRQ_W    = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INT,
      ST_EXT,
      ST_DONE
   } bus_state_e;

   typedef enum int unsigned {
      IRQ_VBLANK = 0,
      IRQ_STAT   = 1,
      IRQ_TIMER  = 2,
      IRQ_SERIAL = 3,
      IRQ_JOYPAD = 4
   } irq_bit_e;

   // Isolates the lowest set bit, which is the highest-priority interrupt.
   function automatic logic [IRQ_W-1:0] lowest_set(input logic [IRQ_W-1:0] v);
      return v & (~v + 5'd1);
   endfunction

endpackage

// File: rtl/bus_responder_interrupt_controller.sv
// IF/IE register pair with ack edge detection and lowest-bit-first retirement.
module interrupt_controller
   import bus_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic [IRQ_W-1:0] src_i,
   input  logic             ack_i,
   input  logic             wr_if_i,
   input  logic             wr_ie_i,
   input  logic [7:0]       wr_data_i,
   output logic [IRQ_W-1:0] if_o,
   output logic [7:0]       ie_o,
   output logic [IRQ_W-1:0] pending_o
);

   logic [IRQ_W-1:0] if_q, if_d;
   logic [7:0]       ie_q, ie_d;
   logic             ack_q;

   assign pending_o = if_q & ie_q[IRQ_W-1:0];
   assign if_o      = if_q;
   assign ie_o      = ie_q;

   // Sources are ORed in last so a same-cycle pulse survives both a write and an ack.
   always_comb begin
      if_d = if_q;
      ie_d = ie_q;
      if (wr_if_i) if_d = wr_data_i[IRQ_W-1:0];
      if (wr_ie_i) ie_d = wr_data_i;
      if (ack_i && !ack_q) if_d = if_d & ~lowest_set(pending_o);
      if_d = if_d | src_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         if_q  <= '0;
         ie_q  <= '0;
         ack_q <= 1'b0;
      end else if (en_i) begin
         if_q  <= if_d;
         ie_q  <= ie_d;
         ack_q <= ack_i;
      end
   end

endmodule

// File: rtl/bus_responder.sv
// CPU-facing memory responder: HRAM, IF/IE registers and a timed external port.
module bus_responder
   import bus_pkg::*;
#(
   parameter logic [15:0] HRAM_BASE   = 16'hFF80,
   parameter int unsigned EXT_TIMEOUT = 16
) (
   input  logic        i_Clk,
   input  logic        i_Reset_n,
   input  logic        i_Enable,
   input  logic [15:0] i_Address,
   input  logic        i_Address_Valid,
   input  logic        i_Read,
   input  logic        i_Write,
   input  logic [7:0]  i_Data,
   output logic [7:0]  o_Data,
   output logic        o_Ready,
   input  logic [4:0]  i_Irq_Sources,
   output logic [4:0]  o_Interrupts,
   input  logic        i_Int_Ack,
   output logic [15:0] o_Ext_Address,
   output logic [7:0]  o_Ext_Data,
   input  logic [7:0]  i_Ext_Data,
   output logic        o_Ext_Read,
   output logic        o_Ext_Write,
   input  logic        i_Ext_Ready
);

   localparam int unsigned CNT_W = $clog2(EXT_TIMEOUT) + 1;

   bus_state_e       state_q, state_d;
   logic [15:0]      addr_q, addr_d, acc_q, acc_d, ext_addr_q, ext_addr_d;
   logic             wr_q, wr_d, ready_q, ready_d;
   logic             ext_rd_q, ext_rd_d, ext_wr_q, ext_wr_d;
   logic [7:0]       wdata_q, wdata_d, data_q, data_d, ext_data_q, ext_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       hram [0:126];
   logic [IRQ_W-1:0] if_val;
   logic [7:0]       ie_val, int_rdata;
   logic             req, req_is_int, wr_if, wr_ie, hram_we;
   logic [6:0]       rd_idx, wr_idx;

   assign addr_d = i_Address_Valid ? i_Address : addr_q;
   // The o_Ready cycle after an external access is idle, so a still-held strobe is not a new request.
   assign req = (i_Read | i_Write) && (state_q == ST_IDLE) && !ready_q;
   assign req_is_int = (addr_d == IF_ADDR) || (addr_d == IE_ADDR) ||
                       ((addr_d >= HRAM_BASE) && (addr_d <= HRAM_END));
   assign rd_idx = 7'(addr_d - HRAM_BASE);
   assign wr_idx = 7'(acc_q - HRAM_BASE);

   always_comb begin
      if (addr_d == IF_ADDR)      int_rdata = {3'b111, if_val};
      else if (addr_d == IE_ADDR) int_rdata = ie_val;
      else                        int_rdata = hram[rd_idx];
   end

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      wr_d       = wr_q;
      wdata_d    = wdata_q;
      data_d     = data_q;
      ready_d    = 1'b0;
      ext_rd_d   = ext_rd_q;
      ext_wr_d   = ext_wr_q;
      ext_addr_d = ext_addr_q;
      ext_data_d = ext_data_q;
      cnt_d      = cnt_q;
      wr_if      = 1'b0;
      wr_ie      = 1'b0;
      hram_we    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               acc_d   = addr_d;
               wr_d    = i_Write;
               wdata_d = i_Data;
               if (req_is_int) begin
                  // Internal reads complete at the request edge so data and o_Ready appear together.
                  state_d = ST_INT;
                  ready_d = 1'b1;
                  if (!i_Write) data_d = int_rdata;
               end else begin
                  state_d    = ST_EXT;
                  ext_addr_d = addr_d;
                  ext_data_d = i_Data;
                  ext_rd_d   = !i_Write;
                  ext_wr_d   = i_Write;
                  cnt_d      = '0;
               end
            end
         end
         ST_INT: begin
            state_d = ST_IDLE;
            if (wr_q) begin
               if (acc_q == IF_ADDR)      wr_if   = 1'b1;
               else if (acc_q == IE_ADDR) wr_ie   = 1'b1;
               else                       hram_we = 1'b1;
            end
         end
         ST_EXT: begin
            if (i_Ext_Ready) begin
               if (!wr_q) data_d = i_Ext_Data;
               ext_rd_d = 1'b0;
               ext_wr_d = 1'b0;
               state_d  = ST_DONE;
            end else if (cnt_q == CNT_W'(EXT_TIMEOUT - 1)) begin
               if (!wr_q) data_d = 8'hFF;
               ext_rd_d = 1'b0;
               ext_wr_d = 1'b0;
               state_d  = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         acc_q      <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         data_q     <= '1;
         ready_q    <= 1'b0;
         ext_rd_q   <= 1'b0;
         ext_wr_q   <= 1'b0;
         ext_addr_q <= '0;
         ext_data_q <= '0;
         cnt_q      <= '0;
      end else if (i_Enable) begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         acc_q      <= acc_d;
         wr_q       <= wr_d;
         wdata_q    <= wdata_d;
         data_q     <= data_d;
         ready_q    <= ready_d;
         ext_rd_q   <= ext_rd_d;
         ext_wr_q   <= ext_wr_d;
         ext_addr_q <= ext_addr_d;
         ext_data_q <= ext_data_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge i_Clk) begin
      if (i_Enable && hram_we) hram[wr_idx] <= wdata_q;
   end

   interrupt_controller u_irq (
      .clk_i     (i_Clk),
      .rst_ni    (i_Reset_n),
      .en_i      (i_Enable),
      .src_i     (i_Irq_Sources),
      .ack_i     (i_Int_Ack),
      .wr_if_i   (wr_if),
      .wr_ie_i   (wr_ie),
      .wr_data_i (wdata_q),
      .if_o      (if_val),
      .ie_o      (ie_val),
      .pending_o (o_Interrupts)
   );

   assign o_Data        = data_q;
   assign o_Ready       = ready_q;
   assign o_Ext_Read    = ext_rd_q;
   assign o_Ext_Write   = ext_wr_q;
   assign o_Ext_Address = ext_addr_q;
   assign o_Ext_Data    = ext_data_q;

endmodule
